// File: rtl/icache.sv
// icache -- direct-mapped, one-word-per-line instruction cache.
//
// Hits are combinational (zero-cycle) in IDLE. A miss latches the word-aligned
// address and moves to FETCH. FETCH holds iREN/iaddr until the memory
// controller drops iwait, then fills the line and returns to IDLE. The hit is
// seen on the cycle after the fill.
// A fill always completes once it has started; only reset abandons it.
//
// Parameters:
//   SETS     number of lines (power of two, 2..64)
//   PC_ALIGN byte-offset bits ignored in imemaddr
// Ports:
//   CLK, nRST            clock, async active-low reset
//   imemREN, imemaddr    datapath fetch request / byte address
//   ihit, imemload       fetch satisfied this cycle / instruction word (0 when no hit)
//   iREN, iaddr          memory read request / word-aligned address (0 in IDLE)
//   iwait, iload         memory busy / read data
//   hit_count,miss_count saturating statistics (only with ICACHE_STATS_EN)
// Optional feature macro: ICACHE_STATS_EN
module icache #(
  parameter int SETS     = 16,
  parameter int PC_ALIGN = 2
) (
  input  logic        CLK,
  input  logic        nRST,
`ifdef ICACHE_STATS_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - PC_ALIGN;
  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << PC_ALIGN) - 32'd1);

  typedef enum logic {IDLE, FETCH} state_t;
  state_t state, next_state;

  logic [SETS-1:0]            valid;
  logic [SETS-1:0][TAG_W-1:0] tags;
  logic [SETS-1:0][31:0]      data;
  logic [31:0]                missaddr;

  logic [31:0]      line_addr;
  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic             lookup_hit, latch_miss, fill;

  assign line_addr  = imemaddr & ALIGN_MASK;
  assign req_idx    = line_addr[PC_ALIGN +: IDX_W];
  assign req_tag    = line_addr[31 -: TAG_W];
  assign fill_idx   = missaddr[PC_ALIGN +: IDX_W];
  assign fill_tag   = missaddr[31 -: TAG_W];
  assign lookup_hit = valid[req_idx] && (tags[req_idx] == req_tag);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    imemload   = 32'h0;
    iREN       = 1'b0;
    iaddr      = 32'h0;
    latch_miss = 1'b0;
    fill       = 1'b0;
    unique case (state)
      IDLE: begin
        if (imemREN) begin
          if (lookup_hit) begin
            ihit     = 1'b1;
            imemload = data[req_idx];
          end else begin
            latch_miss = 1'b1;
            next_state = FETCH;
          end
        end
      end
      FETCH: begin
        // imemaddr/imemREN are ignored here: a redirect waits for the fill.
        iREN  = 1'b1;
        iaddr = missaddr;
        if (!iwait) begin
          fill       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Valid bits and the miss address are reset; reset forces IDLE so an
  // in-flight fill can never write.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid    <= '0;
      missaddr <= 32'h0;
    end else begin
      if (latch_miss) missaddr        <= line_addr;
      if (fill)       valid[fill_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: valid alone gates hits. Fills overwrite freely.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (ihit && hit_count != 32'hFFFF_FFFF)        hit_count  <= hit_count + 32'd1;
      if (latch_miss && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: inputs change on the falling edge, outputs are
// sampled 1 ns later, and state updates happen on the rising edge.
module tb_icache;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int pass = 0;
  int total = 0;

  icache #(.SETS(16), .PC_ALIGN(2)) dut (
    .CLK(CLK), .nRST(nRST),
`ifdef ICACHE_STATS_EN
    .hit_count(hit_count), .miss_count(miss_count),
`endif
    .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload)
  );

  always #5 CLK = ~CLK;

  // Issue a miss from IDLE and serve it after 'waits' busy cycles. The task
  // returns at a falling edge in IDLE with imemREN dropped. It reports how
  // many cycles iREN was high and whether iaddr stayed on the expected address.
  task automatic run_miss(input logic [31:0] addr, input logic [31:0] dat, input int waits,
                          output int ren_cycles, output bit addr_ok);
    ren_cycles = 0;
    addr_ok    = 1'b1;
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = addr; iwait = 1'b1; iload = 32'h0;
    @(negedge CLK);
    for (int i = 0; i < 32; i++) begin
      #1;
      if (!iREN) break;
      ren_cycles++;
      if (iaddr !== (addr & 32'hFFFF_FFFC)) addr_ok = 1'b0;
      iwait = (ren_cycles <= waits);
      iload = dat;
      @(negedge CLK);
    end
    imemREN = 1'b0; iwait = 1'b1;
  endtask

  task automatic test_reset;
    nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h0;
    #12;
    total++; if (ihit !== 1'b0)      $display("FAIL rst_ihit got %b want 0", ihit); else pass++;
    total++; if (iREN !== 1'b0)      $display("FAIL rst_iREN got %b want 0", iREN); else pass++;
    total++; if (iaddr !== 32'h0)    $display("FAIL rst_iaddr got %h want 0", iaddr); else pass++;
    total++; if (imemload !== 32'h0) $display("FAIL rst_imemload got %h want 0", imemload); else pass++;
    @(negedge CLK); nRST = 1'b1; imemREN = 1'b0;
  endtask

  // Cold miss at 0x0: three busy cycles, so iREN is high for 4 cycles, then the hit.
  task automatic test_cold_miss;
    int ren = 0;
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = 32'h0; iwait = 1'b1;
    #1;
    total++; if (ihit !== 1'b0) $display("FAIL cold_first_ihit got %b want 0", ihit); else pass++;
    total++; if (iREN !== 1'b0) $display("FAIL cold_idle_iREN got %b want 0", iREN); else pass++;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK); #1;
      if (!iREN) break;
      ren++;
      total++; if (iaddr !== 32'h0 || ihit !== 1'b0)
        $display("FAIL cold_fetch_c%0d got iaddr=%h ihit=%b want 0/0", k, iaddr, ihit); else pass++;
      iwait = (ren < 4); iload = 32'h0010_0093;
    end
    total++; if (ren !== 4) $display("FAIL cold_ren_cycles got %0d want 4", ren); else pass++;
    total++; if (ihit !== 1'b1 || imemload !== 32'h0010_0093)
      $display("FAIL cold_hit got ihit=%b load=%h want 1/00100093", ihit, imemload); else pass++;
    iwait = 1'b1;
    imemaddr = 32'h0000_0002;
    #1;
    total++; if (ihit !== 1'b1 || imemload !== 32'h0010_0093)
      $display("FAIL offset_hit got ihit=%b load=%h want 1/00100093", ihit, imemload); else pass++;
    imemREN = 1'b0;
    #1;
    total++; if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0)
      $display("FAIL idle_noren got ihit=%b load=%h iREN=%b want 0/0/0", ihit, imemload, iREN); else pass++;
  endtask

  task automatic test_conflict;
    int ren; bit ok;
    run_miss(32'h04, 32'hAAAA_0004, 1, ren, ok);
    total++; if (ren !== 2 || !ok) $display("FAIL conf_fill04 got ren=%0d ok=%0b want 2/1", ren, ok); else pass++;
    run_miss(32'h44, 32'hBBBB_0044, 0, ren, ok);
    total++; if (ren !== 1 || !ok) $display("FAIL conf_fill44 got ren=%0d ok=%0b want 1/1", ren, ok); else pass++;
    imemREN = 1'b1; imemaddr = 32'h44; #1;
    total++; if (ihit !== 1'b1 || imemload !== 32'hBBBB_0044)
      $display("FAIL conf_hit44 got ihit=%b load=%h want 1/bbbb0044", ihit, imemload); else pass++;
    imemaddr = 32'h04; #1;
    total++; if (ihit !== 1'b0 || imemload !== 32'h0)
      $display("FAIL conf_evicted04 got ihit=%b load=%h want 0/0", ihit, imemload); else pass++;
    imemREN = 1'b0;
  endtask

  task automatic test_redirect;
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = 32'h08; iwait = 1'b1;
    @(negedge CLK); #1;
    imemaddr = 32'h100;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK); #1;
      total++; if (iREN !== 1'b1 || iaddr !== 32'h08 || ihit !== 1'b0)
        $display("FAIL redir_hold_c%0d got iREN=%b iaddr=%h ihit=%b want 1/8/0", k, iREN, iaddr, ihit); else pass++;
    end
    iwait = 1'b0; iload = 32'hCCCC_0008;
    @(negedge CLK); #1;
    iwait = 1'b1;
    total++; if (ihit !== 1'b0 || iREN !== 1'b0) $display("FAIL redir_miss100 got ihit=%b iREN=%b want 0/0", ihit, iREN); else pass++;
    @(negedge CLK); #1;
    total++; if (iREN !== 1'b1 || iaddr !== 32'h100) $display("FAIL redir_iaddr100 got iREN=%b iaddr=%h want 1/100", iREN, iaddr); else pass++;
    iwait = 1'b0; iload = 32'hDDDD_0100;
    @(negedge CLK); #1;
    iwait = 1'b1;
    total++; if (ihit !== 1'b1 || imemload !== 32'hDDDD_0100)
      $display("FAIL redir_hit100 got ihit=%b load=%h want 1/dddd0100", ihit, imemload); else pass++;
    imemaddr = 32'h08; #1;
    total++; if (ihit !== 1'b1 || imemload !== 32'hCCCC_0008)
      $display("FAIL redir_hit08 got ihit=%b load=%h want 1/cccc0008", ihit, imemload); else pass++;
    imemREN = 1'b0;
  endtask

  task automatic test_ren_drop;
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = 32'h10; iwait = 1'b1;
    @(negedge CLK);
    imemREN = 1'b0;
    @(negedge CLK);
    iwait = 1'b0; iload = 32'hEEEE_0010;
    @(negedge CLK); #1;
    iwait = 1'b1;
    total++; if (ihit !== 1'b0 || iREN !== 1'b0) $display("FAIL drop_idle got ihit=%b iREN=%b want 0/0", ihit, iREN); else pass++;
    imemREN = 1'b1; #1;
    total++; if (ihit !== 1'b1 || imemload !== 32'hEEEE_0010)
      $display("FAIL drop_hit got ihit=%b load=%h want 1/eeee0010", ihit, imemload); else pass++;
    imemREN = 1'b0;
  endtask

  task automatic test_reset_mid_fetch;
    int ren; bit ok;
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = 32'h0C; iwait = 1'b1;
    @(negedge CLK); #1;
    total++; if (iREN !== 1'b1 || iaddr !== 32'h0C) $display("FAIL rmf_fetch got iREN=%b iaddr=%h want 1/c", iREN, iaddr); else pass++;
    nRST = 1'b0; #1;
    total++; if (iREN !== 1'b0 || iaddr !== 32'h0) $display("FAIL rmf_async got iREN=%b iaddr=%h want 0/0", iREN, iaddr); else pass++;
    iwait = 1'b0; iload = 32'h1234_000C;
    @(negedge CLK);
    nRST = 1'b1; iwait = 1'b1; #1;
    total++; if (ihit !== 1'b0) $display("FAIL rmf_miss0c got ihit=%b want 0", ihit); else pass++;
    imemaddr = 32'h0; #1;
    total++; if (ihit !== 1'b0) $display("FAIL rmf_miss00 got ihit=%b want 0", ihit); else pass++;
    imemREN = 1'b0;
    run_miss(32'h0C, 32'h5678_000C, 0, ren, ok);
    total++; if (ren !== 1 || !ok) $display("FAIL rmf_refill got ren=%0d ok=%0b want 1/1", ren, ok); else pass++;
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats;
    int ren; bit ok;
    @(negedge CLK); nRST = 1'b0;
    @(negedge CLK); nRST = 1'b1;
    total++; if (hit_count !== 32'h0 || miss_count !== 32'h0)
      $display("FAIL stats_rst got hit=%0d miss=%0d want 0/0", hit_count, miss_count); else pass++;
    run_miss(32'h200, 32'h0000_0200, 1, ren, ok);
    run_miss(32'h204, 32'h0000_0204, 0, ren, ok);
    imemREN = 1'b1; imemaddr = 32'h200;
    repeat (5) @(negedge CLK);
    imemREN = 1'b0; #1;
    total++; if (hit_count !== 32'd5 || miss_count !== 32'd2)
      $display("FAIL stats_count got hit=%0d miss=%0d want 5/2", hit_count, miss_count); else pass++;
  endtask
`endif

  initial begin
    test_reset;
    test_cold_miss;
    test_conflict;
    test_redirect;
    test_ren_drop;
    test_reset_mid_fetch;
`ifdef ICACHE_STATS_EN
    test_stats;
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
